// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state encoding and operation codes for the serial adder/subtractor.
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: DIGIT-wide ripple slice computing a_d + (b_d ^ sub) + cin.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             sub,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout
);
  assign {cout, s_d} = (DIGIT+1)'(a_d) + (DIGIT+1)'(b_d ^ {DIGIT{sub}}) + (DIGIT+1)'(cin);
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/subtract with valid/ready handshakes.
// Define ADDSUB_SAT_EN to clamp signed-overflow results instead of wrapping.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [31:0] sh;
  logic [WIDTH-1:0] a_sh, b_sh, dmask, raw, fin;
  logic [DIGIT-1:0] s_dig;
  logic c_dig, last, ovf_w;
  assign sh    = 32'(cnt_q) * 32'(DIGIT);
  assign a_sh  = opa_q >> sh;
  assign b_sh  = opb_q >> sh;
  assign dmask = WIDTH'({DIGIT{1'b1}}) << sh;
  assign last  = cnt_q == CW'(N - 1);
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d  (a_sh[DIGIT-1:0]),
    .b_d  (b_sh[DIGIT-1:0]),
    .sub  (sub_q),
    .cin  (carry_q),
    .s_d  (s_dig),
    .cout (c_dig)
  );
  // raw merges the digit being finished into the partial result
  assign raw   = (res_q & ~dmask) | (WIDTH'(s_dig) << sh);
  assign ovf_w = (opa_q[WIDTH-1] == (opb_q[WIDTH-1] ^ sub_q)) && (raw[WIDTH-1] != opa_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
  assign fin = ovf_w ? {opa_q[WIDTH-1], {(WIDTH-1){~opa_q[WIDTH-1]}}} : raw;
`else
  assign fin = raw;
`endif
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (state_q == IDLE && in_valid) begin
      opa_d   = a;
      opb_d   = b;
      sub_d   = sub;
      cnt_d   = '0;
      carry_d = (sub == OP_SUB);
      state_d = RUN;
    end else if (state_q == RUN) begin
      carry_d = c_dig;
      cnt_d   = cnt_q + 1'b1;
      res_d   = last ? fin : raw;
      if (last) begin
        cout_d  = c_dig;
        ovf_d   = ovf_w;
        zero_d  = fin == '0;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vector table plus stall, reset-abort and single-digit latency sequences.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf, zero;
  logic [15:0] result;
  logic rst2_n = 1'b0;
  logic in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic in_ready2, out_valid2, cout2, ovf2, zero2;
  logic [15:0] result2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .cout(cout2), .ovf(ovf2), .zero(zero2)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // drives one operation into dut, returns cycles from accept edge to out_valid
  task automatic start_op(input logic [15:0] ai, input logic [15:0] bi, input logic si, output int lat);
    a = ai; b = bi; sub = si; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[9];
  int lat;
  logic [15:0] held;

  initial begin
    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0004, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
`else
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
`endif
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      pop();
      chk($sformatf("v%0d_pop_out_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_pop_in_ready", i), 32'(in_ready), 32'd1);
    end

    // back-pressure in DONE with spurious in_valid
    start_op(16'h0100, 16'h0023, 1'b0, lat);
    held = 16'h0123;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_result", i), 32'(result), 32'(held));
      chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    pop();
    chk("stall_pop_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("stall_no_accept_in_ready", 32'(in_ready), 32'd1);
    chk("stall_no_accept_result", 32'(result), 32'(held));

    // asynchronous reset in the second RUN cycle
    a = 16'h1111; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_out_valid", 32'(out_valid), 32'd0);
    start_op(16'h0001, 16'h0002, 1'b0, lat);
    chk("post_abort_result", 32'(result), 32'h0003);
    pop();

    // DIGIT == WIDTH: one-cycle latency
    a = 16'h0001; b = 16'h0002; sub = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d16_latency", 32'(lat), 32'd1);
    chk("d16_result", 32'(result2), 32'h0003);
    chk("d16_flags", {29'd0, cout2, ovf2, zero2}, 32'd0);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    chk("d16_pop_in_ready", 32'(in_ready2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects A+B, 1 selects A-B (A + ~B + 1).
REQ-010 The block SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port result, output, WIDTH bits: sum or difference.
REQ-013 The block SHALL have port cout, output, 1 bit: raw carry out of the MSB; for subtract, 1 means no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 The block SHALL have port zero, output, 1 bit: result equals 0.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, in_valid=1 SHALL accept the operation: latch a, b and sub, clear the digit counter, set the carry register to sub, and go to RUN.
REQ-018 Each RUN cycle SHALL add digit k of A to digit k of B, with B XOR-ed with sub, plus the carry register, store the DIGIT-bit sum into result digit k, update the carry, and increment k.
REQ-019 After digit N-1, where N=WIDTH/DIGIT, the block SHALL go to DONE with out_valid=1, N cycles after the accept edge.
REQ-020 In DONE, result, cout, ovf and zero SHALL hold stable until out_ready=1; that edge SHALL return the block to IDLE and clear out_valid.
REQ-021 in_valid outside IDLE SHALL be ignored with no effect on state or outputs.
REQ-022 ovf SHALL be (A[MSB] == Beff[MSB]) && (raw_result[MSB] != A[MSB]), where Beff is B XOR-ed with sub.
REQ-023 zero SHALL be evaluated on the final result output, after any saturation.
REQ-024 When DIGIT equals WIDTH, latency SHALL be 1 cycle.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of the MSB reported only on cout.

Reset
REQ-026 When rst_n=0, the block SHALL immediately force state to IDLE, out_valid=0, result=0, cout=0, ovf=0, zero=0, counter=0 and carry=0, so in_ready=1.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation and discard any partial result.

Configuration
REQ-028 When macro ADDSUB_SAT_EN is defined, a signed overflow result SHALL be clamped: positive overflow to 0111..1 and negative overflow to 1000..0; ovf SHALL still read 1.
REQ-029 When ADDSUB_SAT_EN is undefined, result SHALL wrap (raw two's complement) and no clamp logic SHALL exist.

Structure
REQ-030 Package addsub_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the op encoding constants OP_ADD=0 and OP_SUB=1.
REQ-031 The combinational sub-module addsub_digit SHALL implement a DIGIT-wide ripple slice with inputs a_d, b_d, sub and cin and outputs s_d and cout; it SHALL be instantiated once and reused each cycle.

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-032 The bench SHALL apply 0x0001+0x0002 and check result 0x0003, cout 0, ovf 0, zero 0, with out_valid rising exactly 4 cycles after accept.
REQ-033 The bench SHALL apply 0x0004-0x0003 and check result 0x0001 with cout 1, then 0xFFFF+0x0001 and check result 0x0000, cout 1, zero 1, ovf 0.
REQ-034 The bench SHALL apply 0x7FFF+0x0001 and check result 0x8000 with ovf 1 without the macro, or result 0x7FFF with ovf 1 with ADDSUB_SAT_EN.
REQ-035 The bench SHALL apply 0x8000-0x0001 and check result 0x7FFF with ovf 1 without the macro, or result 0x8000 with ovf 1 with ADDSUB_SAT_EN.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles in DONE while pulsing in_valid, and check that result is stable, in_ready=0 and the new operation is not accepted.
REQ-037 The bench SHALL drop rst_n in cycle 2 of RUN and check that out_valid=0, in_ready=1 and result=0 immediately; it SHALL also rerun case REQ-032 with DIGIT=16 and check 1-cycle latency.
